l2_write_buffer: RTL

L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

---
 rtl/l2_write_buffer_if.sv | 23 ++
 rtl/l2_write_buffer.sv | 54 +++++
 2 files changed

// File: rtl/l2_write_buffer_if.sv
// l2_write_buffer_if: requester-side and physical-memory-side signals of the L2 write buffer
interface l2_write_buffer_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l2_write_buffer.sv
// l2_write_buffer: one-line posted write buffer on the L2 side; define L2WB_FORWARD_EN to serve matching reads from the buffer
module l2_write_buffer (
  input logic clk,
  input logic reset,
  l2_write_buffer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]   state, state_n, rd_next;
  logic         valid, accept_wr, fwd;
  logic [11:0]  tag, line;
  logic [127:0] data, rd_reg;
  assign line      = bus.mem_address[15:4];
  assign accept_wr = state == IDLE && !bus.mem_read && bus.mem_write && !valid;
`ifdef L2WB_FORWARD_EN
  assign fwd     = state == IDLE && bus.mem_read && valid && tag == line;
  assign rd_next = fwd ? RESP : FETCH;
`else
  assign fwd     = 1'b0;
  assign rd_next = valid ? DRAIN : FETCH;
`endif
  // reads win over writes; a write or an idle cycle with a full buffer drains it first
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = bus.mem_read ? rd_next : valid ? DRAIN : bus.mem_write ? RESP : IDLE;
    else if (state == DRAIN) state_n = bus.pmem_resp ? IDLE : DRAIN;
    else if (state == FETCH) state_n = bus.pmem_resp ? RESP : FETCH;
  end
  // state, buffered line and read register; reset discards any buffered line
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      valid  <= 1'b0;
      rd_reg <= '0;
    end else begin
      state <= state_n;
      if (accept_wr) begin
        valid <= 1'b1;
        tag   <= line;
        data  <= bus.mem_wdata;
      end else if (state == DRAIN && bus.pmem_resp) valid <= 1'b0;
      if (state == FETCH && bus.pmem_resp) rd_reg <= bus.pmem_rdata;
      else if (fwd) rd_reg <= data;
    end
  end
  assign bus.mem_resp     = state == RESP;
  assign bus.mem_rdata    = rd_reg;
  assign bus.pmem_read    = state == FETCH;
  assign bus.pmem_write   = state == DRAIN;
  assign bus.pmem_address = {state == FETCH ? line : tag, 4'h0};
  assign bus.pmem_wdata   = data;
endmodule
